regfile_wr_arb: RTL and testbench
=================================

REGFILE_WR_ARB -- requirements
Module: regfile_wr_arb

Interface
REQ-001 SHALL have parameter CLEAR_ON_RESET, default 1: 1 = zero-sweep registers 1..31 after reset; 0 = go straight to RUN.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port a_valid  input  1  requester A (ALU writeback) has a write pending.
REQ-005 SHALL have port a_addr  input  5  requester A destination register.
REQ-006 SHALL have port a_data  input  32  requester A write data.
REQ-007 SHALL have port a_ready  output  1  requester A write accepted this cycle when a_valid is also high.
REQ-008 SHALL have ports b_valid, b_addr, b_data, b_ready with the same widths and meanings for requester B (load writeback).
REQ-009 SHALL have port we3  output  1  register-file write enable.
REQ-010 SHALL have port wa3  output  5  register-file write address.
REQ-011 SHALL have port wd3  output  32  register-file write data.
REQ-012 SHALL have port busy  output  1  high while the clear sweep runs.
REQ-013 SHALL have port last_grant_b  output  1  1 when the most recent contested grant went to B.

Function
REQ-014 SHALL implement a two-state FSM: CLEAR and RUN.
REQ-015 SHALL hold a 5-bit sweep counter; on entering CLEAR it is 1.
REQ-016 In CLEAR, each cycle SHALL register we3=1, wa3=counter, wd3=0, then increment; after issuing address 31 it SHALL enter RUN (31 sweep writes, 31 cycles).
REQ-017 busy SHALL be 1 in CLEAR and 0 in RUN; a_ready and b_ready SHALL be 0 in CLEAR.
REQ-018 In RUN, handshake: transfer occurs when valid & ready in the same cycle; ready SHALL be combinational from valid and the priority bit, independent of ready.
REQ-019 In RUN, only one valid requester: that requester SHALL see ready=1, the other ready=0.
REQ-020 Both valid: the requester named by the priority bit SHALL see ready=1, the other 0; the priority bit then SHALL toggle (round-robin); last_grant_b SHALL record the winner.
REQ-021 Uncontested grants SHALL NOT change the priority bit or last_grant_b.
REQ-022 Neither valid: both ready SHALL be 0.
REQ-023 Latency: a transfer in cycle N SHALL drive we3/wa3/wd3 registered in cycle N+1, so the file commits on the edge ending cycle N+1; one write per cycle sustained.
REQ-024 Cycles without a transfer SHALL register we3=0; wa3/wd3 SHALL hold their previous values.
REQ-025 A transfer with addr 0 SHALL complete the handshake but register we3=0 (r0 is never written).
REQ-026 Requester data and address SHALL be sampled only at the transfer edge; later changes SHALL NOT affect the issued write.

Reset
REQ-027 reset high at an edge SHALL force we3=0, wa3=0, wd3=0, priority bit=A, last_grant_b=0, counter=1, with priority over all other activity.
REQ-028 After reset, state SHALL be CLEAR if CLEAR_ON_RESET=1, else RUN; busy SHALL follow the state.
REQ-029 reset asserted mid-sweep or mid-transfer SHALL abort it; the pending write SHALL NOT issue and the sweep SHALL restart at address 1.
REQ-030 While reset is high, a_ready and b_ready SHALL be 0.

Verification
REQ-031 Sweep: reset 1 cycle, CLEAR_ON_RESET=1 -> busy high 31 cycles, we3=1 with wa3=1..31 ascending, wd3=0; then busy=0.
REQ-032 Single write: RUN, a_valid=1, a_addr=3, a_data=12 for one cycle -> a_ready=1 that cycle; next cycle we3=1, wa3=3, wd3=12; reading reg 3 afterwards returns 12.
REQ-033 Contention: a_valid=b_valid=1 four cycles, A addr 1 data 15, B addr 5 data 13 -> grants A,B,A,B; we3 writes alternate wa3=1/5; last_grant_b toggles 0,1,0,1.
REQ-034 r0 guard: b_valid=1, b_addr=0, b_data=32'hFFFFFFFF -> b_ready=1, next cycle we3=0; reg 0 still reads 0.
REQ-035 Reset mid-sweep: assert reset when wa3=10 -> next cycle we3=0, busy=1; sweep restarts at wa3=1 and completes 31 writes.
REQ-036 Hold: a_valid=1 while CLEAR active -> a_ready=0 throughout; first RUN cycle a_ready=1 and the write issues one cycle later.

Source files
------------

// File: rtl/regfile_wr_arb.sv
// rtl/regfile_wr_arb.sv - two-requester register-file write arbiter with post-reset clear sweep
module regfile_wr_arb #(
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_valid,
    input  logic [4:0]  a_addr,
    input  logic [31:0] a_data,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [4:0]  b_addr,
    input  logic [31:0] b_data,
    output logic        b_ready,
    output logic        we3,
    output logic [4:0]  wa3,
    output logic [31:0] wd3,
    output logic        busy,
    output logic        last_grant_b
);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } arbState_t;

    arbState_t   state;
    arbState_t   stateNext;
    logic [4:0]  sweepCnt;
    logic        prioB;
    logic        aGrant;
    logic        bGrant;
    logic        contested;

    // State register; reset picks the start state from the parameter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CLEAR_ON_RESET ? CLEAR : RUN;
        end else begin
            state <= stateNext;
        end
    end

    // Next state and grant decode; grants depend only on valids, priority and state.
    always_comb begin
        stateNext = state;
        aGrant    = 1'b0;
        bGrant    = 1'b0;
        contested = 1'b0;
        case (state)
            CLEAR: begin
                if (sweepCnt == 5'd31) begin
                    stateNext = RUN;
                end
            end
            RUN: begin
                contested = a_valid & b_valid;
                if (contested) begin
                    aGrant = ~prioB;
                    bGrant = prioB;
                end else begin
                    aGrant = a_valid;
                    bGrant = b_valid;
                end
            end
        endcase
        if (reset) begin
            aGrant    = 1'b0;
            bGrant    = 1'b0;
            contested = 1'b0;
        end
    end

    assign a_ready = aGrant;
    assign b_ready = bGrant;
    assign busy    = (state == CLEAR);

    // Sweep address counter; starts at 1 because r0 never needs clearing.
    always_ff @(posedge clk) begin
        if (reset) begin
            sweepCnt <= 5'd1;
        end else if (state == CLEAR) begin
            sweepCnt <= sweepCnt + 5'd1;
        end
    end

    // Round-robin priority; only a contested grant moves it.
    always_ff @(posedge clk) begin
        if (reset) begin
            prioB        <= 1'b0;
            last_grant_b <= 1'b0;
        end else if (contested) begin
            prioB        <= ~prioB;
            last_grant_b <= bGrant;
        end
    end

    // Registered write port; an r0 transfer completes the handshake but writes nothing.
    always_ff @(posedge clk) begin
        if (reset) begin
            we3 <= 1'b0;
            wa3 <= 5'd0;
            wd3 <= 32'd0;
        end else if (state == CLEAR) begin
            we3 <= 1'b1;
            wa3 <= sweepCnt;
            wd3 <= 32'd0;
        end else if (aGrant) begin
            we3 <= |a_addr;
            if (|a_addr) begin
                wa3 <= a_addr;
                wd3 <= a_data;
            end
        end else if (bGrant) begin
            we3 <= |b_addr;
            if (|b_addr) begin
                wa3 <= b_addr;
                wd3 <= b_data;
            end
        end else begin
            we3 <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_wr_arb.sv
// tb/tb_regfile_wr_arb.sv - randomized self-checking bench for regfile_wr_arb
module tb_regfile_wr_arb;

    logic        clk;
    logic        reset;
    logic        a_valid;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic        a_ready;
    logic        b_valid;
    logic [4:0]  b_addr;
    logic [31:0] b_data;
    logic        b_ready;
    logic        we3;
    logic [4:0]  wa3;
    logic [31:0] wd3;
    logic        busy;
    logic        last_grant_b;

    regfile_wr_arb #(.CLEAR_ON_RESET(1'b1)) dut (
        .clk          (clk),
        .reset        (reset),
        .a_valid      (a_valid),
        .a_addr       (a_addr),
        .a_data       (a_data),
        .a_ready      (a_ready),
        .b_valid      (b_valid),
        .b_addr       (b_addr),
        .b_data       (b_data),
        .b_ready      (b_ready),
        .we3          (we3),
        .wa3          (wa3),
        .wd3          (wd3),
        .busy         (busy),
        .last_grant_b (last_grant_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file driven by the DUT write port; r0 is hardwired zero.
    logic [31:0] rf [32];
    always @(posedge clk) begin
        if (we3 && wa3 != 5'd0) rf[wa3] <= wd3;
    end

    // Reference model: what the write port should show and what the file should hold.
    bit          mSweep;
    int          mSweepAddr;
    bit          mPrioB;
    bit          mLastB;
    bit          mWe;
    logic [4:0]  mWa;
    logic [31:0] mWd;
    logic [31:0] mRegs [32];

    int nChecks = 0;
    int nFails  = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cycle(input bit rst, input bit av, input logic [4:0] aa, input logic [31:0] ad,
                         input bit bv, input logic [4:0] ba, input logic [31:0] bd, input bit chk);
        bit winA;
        bit winB;
        @(negedge clk);
        reset   = rst;
        a_valid = av;
        a_addr  = aa;
        a_data  = ad;
        b_valid = bv;
        b_addr  = ba;
        b_data  = bd;
        #1;
        winA = 1'b0;
        winB = 1'b0;
        if (!rst && !mSweep) begin
            if (av && bv) begin
                winA = !mPrioB;
                winB = mPrioB;
            end else begin
                winA = av;
                winB = bv;
            end
        end
        if (chk) begin
            checkVal("a_ready", 32'(a_ready), 32'(winA));
            checkVal("b_ready", 32'(b_ready), 32'(winB));
            checkVal("busy", 32'(busy), 32'(mSweep));
            checkVal("last_grant_b", 32'(last_grant_b), 32'(mLastB));
            checkVal("we3", 32'(we3), 32'(mWe));
            checkVal("wa3", 32'(wa3), 32'(mWa));
            checkVal("wd3", wd3, mWd);
        end
        if (mWe && mWa != 5'd0) mRegs[mWa] = mWd;
        if (rst) begin
            mSweep     = 1'b1;
            mSweepAddr = 1;
            mWe        = 1'b0;
            mWa        = 5'd0;
            mWd        = 32'd0;
            mPrioB     = 1'b0;
            mLastB     = 1'b0;
        end else if (mSweep) begin
            mWe = 1'b1;
            mWa = 5'(mSweepAddr);
            mWd = 32'd0;
            if (mSweepAddr == 31) mSweep = 1'b0;
            else mSweepAddr++;
        end else begin
            if (av && bv) begin
                mPrioB = !mPrioB;
                mLastB = winB;
            end
            if (winA && aa != 5'd0) begin
                mWe = 1'b1; mWa = aa; mWd = ad;
            end else if (winB && ba != 5'd0) begin
                mWe = 1'b1; mWa = ba; mWd = bd;
            end else begin
                mWe = 1'b0;
            end
        end
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
    endtask

    bit         reached;
    logic [3:0] grantsB;

    initial begin
        reset = 1'b1; a_valid = 1'b0; a_addr = 5'd0; a_data = 32'd0;
        b_valid = 1'b0; b_addr = 5'd0; b_data = 32'd0;
        mWe = 1'b0; mWa = 5'd0; mWd = 32'd0; mSweep = 1'b1; mSweepAddr = 1;
        mPrioB = 1'b0; mLastB = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rf[i]    = 32'd0;
            mRegs[i] = 32'd0;
        end

        // Reset, then hold a write on A through the whole sweep.
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
        checkVal("reset_a_ready", 32'(a_ready), 32'd0);
        reached = 1'b0;
        for (int i = 0; i < 40 && !reached; i++) begin
            cycle(1'b0, 1'b1, 5'd3, 32'd12, 1'b0, 5'd0, 32'd0, 1'b1);
            if (!mSweep) reached = 1'b1;
        end
        checkVal("sweep_done", 32'(reached), 32'd1);
        cycle(1'b0, 1'b1, 5'd3, 32'd12, 1'b0, 5'd0, 32'd0, 1'b1);
        checkVal("first_run_a_ready", 32'(a_ready), 32'd1);
        idle();
        checkVal("single_we3", 32'(we3), 32'd1);
        checkVal("single_wa3", 32'(wa3), 32'd3);
        checkVal("single_wd3", wd3, 32'd12);
        idle();
        checkVal("rf3", rf[3], 32'd12);

        // Contention: four cycles both valid.
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, 5'd1, 32'd15, 1'b1, 5'd5, 32'd13, 1'b1);
            grantsB[i] = b_ready;
        end
        checkVal("contention_grants", 32'(grantsB), 32'h0000000a);
        idle();
        checkVal("contention_last_wa3", 32'(wa3), 32'd5);
        checkVal("contention_last_grant_b", 32'(last_grant_b), 32'd1);

        // r0 guard.
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1);
        checkVal("r0_b_ready", 32'(b_ready), 32'd1);
        idle();
        checkVal("r0_we3", 32'(we3), 32'd0);
        idle();
        checkVal("rf0", rf[0], 32'd0);

        // Reset mid-sweep at wa3 == 10.
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
        reached = 1'b0;
        for (int i = 0; i < 40 && !reached; i++) begin
            idle();
            if (mWe && mWa == 5'd10) reached = 1'b1;
        end
        checkVal("reach_wa3_10", 32'(reached), 32'd1);
        cycle(1'b1, 1'b1, 5'd7, 32'd99, 1'b0, 5'd0, 32'd0, 1'b1);
        idle();
        checkVal("midsweep_we3", 32'(we3), 32'd0);
        checkVal("midsweep_busy", 32'(busy), 32'd1);
        idle();
        checkVal("restart_wa3", 32'(wa3), 32'd1);
        for (int i = 0; i < 40; i++) idle();

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 99) == 0,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom, 1'b1);
        end

        // Let outstanding writes land, then compare the whole file.
        idle();
        idle();
        for (int i = 0; i < 32; i++) checkVal($sformatf("rf[%0d]", i), rf[i], mRegs[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
